outfifo_ne_streamer: RTL and testbench

Output-side frame buffer for the NE LDPC decoder. It collects decoded hard-decision rows from the decoder core, 16 block columns × 32 bits per write, 16 rows per frame. It then streams each frame out as 32-bit words under a valid/ready handshake. Two ping-pong banks let the core write frame N+1 while frame N drains; this block is the mirror of the input FIFO that loads codeword symbols into the core.

---
 rtl/outfifo_ne_streamer.sv | 99 +++++++++
 tb/tb_outfifo_ne_streamer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/outfifo_ne_streamer.sv
// outfifo_ne_streamer: ping-pong output frame buffer streaming 32-bit words; define OUTFIFO_INFOONLY_EN to stream only 223 words per frame
module outfifo_ne_streamer (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] DIN_nb,
    input  logic [3:0]   WA,
    input  logic         wr_en,
    input  logic         load_done,
    output logic         wr_rdy,
    output logic [31:0]  dout,
    output logic         dout_valid,
    input  logic         out_ready,
    output logic         frame_start,
    output logic         frame_end,
    output logic         overflow
);
    localparam int NB = 16;
    localparam int BW = 32;
    localparam int ROWS = 16;
`ifdef OUTFIFO_INFOONLY_EN
    localparam logic [8:0] LAST = 9'd222;
`else
    localparam logic [8:0] LAST = 9'd255;
`endif
    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_n;
    logic [NB-1:0][BW-1:0] mem [2*ROWS];
    logic [8:0] count, count_n;
    logic wbank, rbank;
    logic [1:0] full;
    logic fetch, rel;
    logic [BW-1:0] word;
    assign wr_rdy = ~full[wbank];
    assign word = mem[{rbank, count[3:0]}][count[7:4]];
    // row storage; a full bank rejects writes and contents survive reset
    always_ff @(posedge clk) begin
        if (rst && wr_en && !full[wbank]) mem[{wbank, WA}] <= DIN_nb;
    end
    // read state and word counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end
    // enter STREAM once the read bank fills; leave when the last word is accepted
    always_comb begin
        state_n = state;
        count_n = count;
        rel = dout_valid && out_ready && frame_end;
        fetch = state == STREAM && (!dout_valid || out_ready) && count <= LAST;
        if (state == IDLE && full[rbank]) begin
            state_n = STREAM;
            count_n = '0;
        end
        if (fetch) count_n = count + 9'd1;
        if (rel) state_n = IDLE;
    end
    // bank pointers, full flags and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            full <= 2'b00;
            overflow <= 1'b0;
        end else begin
            if (load_done && !full[wbank]) begin
                full[wbank] <= 1'b1;
                wbank <= ~wbank;
            end
            if (rel) begin
                full[rbank] <= 1'b0;
                rbank <= ~rbank;
            end
            if ((wr_en || load_done) && full[wbank]) overflow <= 1'b1;
        end
    end
    // output register: load a word when empty or being accepted, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= '0;
            dout_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_end <= 1'b0;
        end else if (fetch) begin
            dout <= word;
            dout_valid <= 1'b1;
            frame_start <= count == 9'd0;
            frame_end <= count == LAST;
        end else if (out_ready) begin
            dout_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_end <= 1'b0;
        end
    end
endmodule

// File: tb/tb_outfifo_ne_streamer.sv
// tb_outfifo_ne_streamer: directed and random checks of outfifo_ne_streamer against a frame-queue reference model
module tb_outfifo_ne_streamer;
`ifdef OUTFIFO_INFOONLY_EN
    localparam int LAST = 222;
`else
    localparam int LAST = 255;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [511:0] DIN_nb = '0;
    logic [3:0] WA = '0;
    logic wr_en = 1'b0;
    logic load_done = 1'b0;
    logic out_ready = 1'b0;
    logic wr_rdy, dout_valid, frame_start, frame_end, overflow;
    logic [31:0] dout;

    outfifo_ne_streamer dut (
        .clk(clk), .rst(rst), .DIN_nb(DIN_nb), .WA(WA), .wr_en(wr_en),
        .load_done(load_done), .wr_rdy(wr_rdy), .dout(dout), .dout_valid(dout_valid),
        .out_ready(out_ready), .frame_start(frame_start), .frame_end(frame_end),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    logic [511:0] ref_mem [2][16];
    logic [31:0] q[$];
    int ldq[$];
    int nfull = 0, wpar = 0, pos = 0, cyc_n = 0, prev_rel = 0;
    bit ovf = 0, started = 0;
    logic [31:0] got [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [511:0] rnd_row();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic cyc(input logic we, input logic [3:0] a, input logic [511:0] d, input logic ld, input logic rdy);
        int nf0;
        bit hold, rel;
        logic [31:0] held;
        wr_en = we; WA = a; DIN_nb = d; load_done = ld; out_ready = rdy;
        nf0 = nfull;
        hold = dout_valid && !rdy;
        held = dout;
        rel = 0;
        if (dout_valid && rdy && q.size() > 0) begin
            chk("word", dout, q[0]);
            chk("frame_start", 32'(frame_start), 32'(pos == 0));
            chk("frame_end", 32'(frame_end), 32'(pos == LAST));
            got[pos] = dout;
            void'(q.pop_front());
            pos++;
            if (pos == LAST + 1) begin
                pos = 0;
                rel = 1;
            end
        end
        if (we && nf0 < 2) ref_mem[wpar][a] = d;
        if ((we || ld) && nf0 == 2) ovf = 1;
        if (ld && nf0 < 2) begin
            for (int k = 0; k <= LAST; k++) q.push_back(ref_mem[wpar][k % 16][(k / 16) * 32 +: 32]);
            ldq.push_back(cyc_n + 1);
            wpar ^= 1;
            nfull++;
        end
        if (rel) begin
            nfull--;
            prev_rel = cyc_n + 1;
            started = 0;
            void'(ldq.pop_front());
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (hold) begin
            chk("hold_valid", 32'(dout_valid), 1);
            chk("hold_dout", dout, held);
        end
        if (dout_valid && !started) begin
            if (ldq.size() == 0) chk("spurious_valid", 32'(dout_valid), 0);
            else begin
                chk("frame_start_new", 32'(frame_start), 1);
                chk("start_cycle", cyc_n, (ldq[0] > prev_rel ? ldq[0] : prev_rel) + 2);
            end
            started = 1;
        end
        chk("wr_rdy", 32'(wr_rdy), 32'(nfull < 2));
        chk("overflow", 32'(overflow), 32'(ovf));
    endtask

    task automatic do_reset();
        rst = 1'b0; wr_en = 1'b0; load_done = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc_n++;
        q.delete(); ldq.delete();
        nfull = 0; wpar = 0; pos = 0; ovf = 0; started = 0; prev_rel = cyc_n;
        chk("rst_dout", dout, 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_fstart", 32'(frame_start), 0);
        chk("rst_fend", 32'(frame_end), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_wr_rdy", 32'(wr_rdy), 1);
    endtask

    task automatic write_frame(input bit pat, input logic rdy);
        logic [511:0] v;
        logic [3:0] rr;
        for (int r = 0; r < 16; r++) begin
            rr = 4'(r);
            v = rnd_row();
            if (pat) for (int b = 0; b < 16; b++) v[b*32 +: 32] = {rr, 4'(b), 24'hA5A5A5};
            cyc(1'b1, rr, v, 1'b0, rdy);
        end
        cyc(1'b0, 4'd0, '0, 1'b1, rdy);
    endtask

    task automatic drain(input int mode);
        int n;
        logic r;
        n = 0;
        r = 1'b1;
        while ((q.size() > 0 || dout_valid) && n < 3000) begin
            r = mode == 0 ? 1'b1 : mode == 1 ? ~r : 1'($urandom_range(0, 1));
            cyc(1'b0, 4'd0, '0, 1'b0, r);
            n++;
        end
        chk("drain_timeout", 32'(n < 3000), 1);
    endtask

    initial begin
        int n;
        do_reset();
        write_frame(1'b1, 1'b1);
        drain(0);
        chk("word0", got[0], 32'h00A5A5A5);
        chk("word17", got[17], 32'h11A5A5A5);
        chk("wr_rdy_after_frame", 32'(wr_rdy), 1);
        write_frame(1'b0, 1'b1);
        drain(1);
        write_frame(1'b0, 1'b1);
        repeat (10) cyc(1'b0, 4'd0, '0, 1'b0, 1'b1);
        write_frame(1'b0, 1'b1);
        drain(0);
        write_frame(1'b0, 1'b0);
        write_frame(1'b0, 1'b0);
        cyc(1'b1, 4'd3, rnd_row(), 1'b0, 1'b0);
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b0);
        chk("ovf_wr_rdy", 32'(wr_rdy), 0);
        chk("ovf_flag", 32'(overflow), 1);
        drain(2);
        write_frame(1'b0, 1'b1);
        for (int r = 0; r < 16; r++) cyc(1'b1, 4'(r), rnd_row(), 1'b0, 1'b1);
        n = 0;
        while (!(dout_valid && frame_end) && n < 1000) begin
            cyc(1'b0, 4'd0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("sim_reach_end", 32'(dout_valid && frame_end), 1);
        cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);
        chk("sim_wr_rdy", 32'(wr_rdy), 1);
        drain(0);
        write_frame(1'b0, 1'b1);
        n = 0;
        while (pos < 100 && n < 1000) begin
            cyc(1'b0, 4'd0, '0, 1'b0, 1'b1);
            n++;
        end
        chk("mid_reach_100", pos, 100);
        do_reset();
        repeat (5) cyc(1'b0, 4'd0, '0, 1'b0, 1'b1);
        chk("mid_idle_valid", 32'(dout_valid), 0);
        write_frame(1'b0, 1'b1);
        drain(0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
